// File: rtl/rv32i_types.sv
// Shared types for the RV32I control pipeline: the decoded control word, stage
// record, forwarding selects and the helpers that say which sources an opcode reads.
package rv32i_types;

  localparam int RIDX_W = 5;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [3:0]  aluop;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic        load_regfile;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    rv32i_control_word ctrl;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
  } stage_t;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE
  } pipe_act_t;

  function automatic logic uses_rs1(input rv32i_opcode op);
    return !(op == op_lui || op == op_auipc || op == op_jal);
  endfunction

  function automatic logic uses_rs2(input rv32i_opcode op);
    return (op == op_br || op == op_store || op == op_reg);
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection (load-use, or any RAW when forwarding is off)
// and EX operand forwarding selects.
module hazard_unit
  import rv32i_types::*;
#(
  parameter int REG_IDX_W = RIDX_W,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic                 i_id_valid,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_load_rf,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic [REG_IDX_W-1:0] i_ex_rs1,
  input  logic [REG_IDX_W-1:0] i_ex_rs2,
  input  logic                 i_mem_valid,
  input  logic                 i_mem_load_rf,
  input  logic [REG_IDX_W-1:0] i_mem_rd,
  input  logic                 i_wb_valid,
  input  logic                 i_wb_load_rf,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  output logic                 o_stall_req,
  output fwd_sel_t             o_fwd_a,
  output fwd_sel_t             o_fwd_b
);

  // ID sources arrive already masked to zero when the opcode does not read them
  function automatic logic id_reads(input logic [REG_IDX_W-1:0] r,
                                    input logic [REG_IDX_W-1:0] a,
                                    input logic [REG_IDX_W-1:0] b);
    return (r != '0) && ((a == r) || (b == r));
  endfunction

  logic w_ex_writes, w_mem_writes, w_wb_writes;
  logic w_reads_ex, w_reads_mem;
  logic w_load_use, w_raw;

  assign w_ex_writes  = i_ex_valid & i_ex_load_rf & (i_ex_rd != '0);
  assign w_mem_writes = i_mem_valid & i_mem_load_rf & (i_mem_rd != '0);
  assign w_wb_writes  = i_wb_valid & i_wb_load_rf & (i_wb_rd != '0);

  assign w_reads_ex  = id_reads(i_ex_rd, i_id_rs1, i_id_rs2);
  assign w_reads_mem = id_reads(i_mem_rd, i_id_rs1, i_id_rs2);

  assign w_load_use = i_id_valid & i_ex_valid & i_ex_mem_read & w_reads_ex;
  assign w_raw      = i_id_valid & ((w_ex_writes & w_reads_ex) | (w_mem_writes & w_reads_mem));

  always_comb begin
    o_stall_req = w_load_use;
    o_fwd_a     = FWD_RF;
    o_fwd_b     = FWD_RF;
    if (FWD_EN) begin
      if (w_mem_writes && i_mem_rd == i_ex_rs1)     o_fwd_a = FWD_MEM;
      else if (w_wb_writes && i_wb_rd == i_ex_rs1)  o_fwd_a = FWD_WB;
      if (w_mem_writes && i_mem_rd == i_ex_rs2)     o_fwd_b = FWD_MEM;
      else if (w_wb_writes && i_wb_rd == i_ex_rs2)  o_fwd_b = FWD_WB;
    end else begin
      o_stall_req = w_load_use | w_raw;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline registers with stall, redirect-flush and load-use
// bubble priority; hazard and forwarding decisions come from hazard_unit.
module ctrl_pipe
  import rv32i_types::*;
#(
  parameter int REG_IDX_W = RIDX_W,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  rv32i_control_word    id_ctrl,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 mem_stall,
  input  logic                 ex_redirect,
  output logic                 id_stall,
  output logic                 flush_if_id,
  output logic                 ex_valid,
  output logic                 mem_valid,
  output logic                 wb_valid,
  output rv32i_control_word    ex_ctrl,
  output rv32i_control_word    mem_ctrl,
  output rv32i_control_word    wb_ctrl,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [REG_IDX_W-1:0] mem_rd,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 wb_we
);

  stage_t                 r_ex;
  logic                   r_mem_valid, r_wb_valid;
  rv32i_control_word      r_mem_ctrl, r_wb_ctrl;
  logic [REG_IDX_W-1:0]   r_mem_rd, r_wb_rd;

  stage_t                 w_id_s;
  pipe_act_t              w_act;
  logic                   w_stall_req;
  fwd_sel_t               w_fwd_a, w_fwd_b;

  // Invalid entries carry an all-zero record; unread sources are zeroed so
  // they can neither trigger a hazard nor pick up a forward later in EX.
  always_comb begin
    w_id_s = '0;
    if (id_valid) begin
      w_id_s.valid = 1'b1;
      w_id_s.ctrl  = id_ctrl;
      w_id_s.rd    = id_rd;
      w_id_s.rs1   = uses_rs1(id_ctrl.opcode) ? id_rs1 : '0;
      w_id_s.rs2   = uses_rs2(id_ctrl.opcode) ? id_rs2 : '0;
    end
  end

  hazard_unit #(
    .REG_IDX_W (REG_IDX_W),
    .FWD_EN    (FWD_EN)
  ) u_hazard (
    .i_id_valid    (w_id_s.valid),
    .i_id_rs1      (w_id_s.rs1),
    .i_id_rs2      (w_id_s.rs2),
    .i_ex_valid    (r_ex.valid),
    .i_ex_mem_read (r_ex.ctrl.mem_read),
    .i_ex_load_rf  (r_ex.ctrl.load_regfile),
    .i_ex_rd       (r_ex.rd),
    .i_ex_rs1      (r_ex.rs1),
    .i_ex_rs2      (r_ex.rs2),
    .i_mem_valid   (r_mem_valid),
    .i_mem_load_rf (r_mem_ctrl.load_regfile),
    .i_mem_rd      (r_mem_rd),
    .i_wb_valid    (r_wb_valid),
    .i_wb_load_rf  (r_wb_ctrl.load_regfile),
    .i_wb_rd       (r_wb_rd),
    .o_stall_req   (w_stall_req),
    .o_fwd_a       (w_fwd_a),
    .o_fwd_b       (w_fwd_b)
  );

  always_comb begin
    w_act = ACT_ADVANCE;
    if (mem_stall)        w_act = ACT_HOLD;
    else if (ex_redirect) w_act = ACT_FLUSH;
    else if (w_stall_req) w_act = ACT_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem_valid <= 1'b0;
      r_mem_ctrl  <= '0;
      r_mem_rd    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_ctrl   <= '0;
      r_wb_rd     <= '0;
    end else if (w_act != ACT_HOLD) begin
      r_wb_valid  <= r_mem_valid;
      r_wb_ctrl   <= r_mem_ctrl;
      r_wb_rd     <= r_mem_rd;
      r_mem_valid <= r_ex.valid;
      r_mem_ctrl  <= r_ex.ctrl;
      r_mem_rd    <= r_ex.rd;
      r_ex        <= (w_act == ACT_ADVANCE) ? w_id_s : '0;
    end
  end

  assign id_stall    = (w_act == ACT_HOLD) || (w_act == ACT_BUBBLE);
  assign flush_if_id = (w_act == ACT_FLUSH);
  assign ex_valid    = r_ex.valid;
  assign ex_ctrl     = r_ex.ctrl;
  assign ex_rd       = r_ex.rd;
  assign mem_valid   = r_mem_valid;
  assign mem_ctrl    = r_mem_ctrl;
  assign mem_rd      = r_mem_rd;
  assign wb_valid    = r_wb_valid;
  assign wb_ctrl     = r_wb_ctrl;
  assign wb_rd       = r_wb_rd;
  assign fwd_a_sel   = w_fwd_a;
  assign fwd_b_sel   = w_fwd_b;
  assign wb_we       = r_wb_valid & r_wb_ctrl.load_regfile & (r_wb_rd != '0);

  // A load still in MEM has no data yet, so it must never be a forward source
  a_no_fwd_from_load: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_mem_ctrl.mem_read && (fwd_a_sel == 2'b01 || fwd_b_sel == 2'b01)));

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios with literal expectations plus a
// randomized run, both compared every cycle against a stage-list model.
module tb_ctrl_pipe;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  rv32i_control_word id_ctrl;
  logic [4:0]        id_rd, id_rs1, id_rs2;
  logic              mem_stall, ex_redirect;
  logic              id_stall, flush_if_id;
  logic              ex_valid, mem_valid, wb_valid;
  rv32i_control_word ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]        ex_rd, mem_rd, wb_rd;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic              wb_we;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_IDX_W(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .mem_stall(mem_stall), .ex_redirect(ex_redirect),
    .id_stall(id_stall), .flush_if_id(flush_if_id),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wb_we(wb_we)
  );

  // Model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  // Source fields hold only registers the instruction actually reads.
  typedef struct {
    logic              v;
    rv32i_control_word c;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
  } ent_t;

  ent_t m[3];
  int   n_pass = 0;
  int   n_total = 0;
  logic last_stall = 1'b0, last_flush = 1'b0, last_mstall = 1'b0, last_redir = 1'b0;
  rv32i_opcode ops[10] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                           op_load, op_store, op_imm, op_reg, op_csr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit reads1(input rv32i_opcode op);
    return !(op inside {op_lui, op_auipc, op_jal});
  endfunction

  function automatic bit reads2(input rv32i_opcode op);
    return op inside {op_br, op_store, op_reg};
  endfunction

  function automatic rv32i_control_word mk_ctrl(input rv32i_opcode op);
    rv32i_control_word c;
    c = '0;
    c.opcode      = op;
    c.funct3      = 3'($urandom);
    c.aluop       = 4'($urandom);
    c.alu_src_imm = !(op inside {op_reg, op_br});
    case (op)
      op_load:        begin c.mem_read = 1'b1; c.load_regfile = 1'b1; end
      op_store:       c.mem_write = 1'b1;
      op_br:          ;
      default:        c.load_regfile = 1'b1;
    endcase
    return c;
  endfunction

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 1'b0; e.c = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
    return e;
  endfunction

  function automatic bit id_depends_on(input logic [4:0] r);
    if (r == 0 || !id_valid) return 1'b0;
    return (reads1(id_ctrl.opcode) && id_rs1 == r) || (reads2(id_ctrl.opcode) && id_rs2 == r);
  endfunction

  function automatic bit load_use_now();
    return m[0].v && m[0].c.mem_read && id_depends_on(m[0].rd);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs != 0 && m[1].v && m[1].c.load_regfile && m[1].rd == rs) return 2'b01;
    if (rs != 0 && m[2].v && m[2].c.load_regfile && m[2].rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = empty_ent();
  endtask

  task automatic model_step();
    bit hz;
    hz = load_use_now();
    if (!mem_stall) begin
      m[2] = m[1];
      m[1] = m[0];
      m[0] = empty_ent();
      if (!ex_redirect && !hz && id_valid) begin
        m[0].v   = 1'b1;
        m[0].c   = id_ctrl;
        m[0].rd  = id_rd;
        m[0].rs1 = reads1(id_ctrl.opcode) ? id_rs1 : 5'd0;
        m[0].rs2 = reads2(id_ctrl.opcode) ? id_rs2 : 5'd0;
      end
    end
  endtask

  task automatic compare();
    logic exp_stall, exp_flush;
    exp_stall = mem_stall || (!ex_redirect && load_use_now());
    exp_flush = !mem_stall && ex_redirect;
    chk("id_stall",    32'(id_stall),    32'(exp_stall));
    chk("flush_if_id", 32'(flush_if_id), 32'(exp_flush));
    chk("ex_valid",    32'(ex_valid),    32'(m[0].v));
    chk("mem_valid",   32'(mem_valid),   32'(m[1].v));
    chk("wb_valid",    32'(wb_valid),    32'(m[2].v));
    chk("ex_ctrl",     32'(ex_ctrl),     32'(m[0].c));
    chk("mem_ctrl",    32'(mem_ctrl),    32'(m[1].c));
    chk("wb_ctrl",     32'(wb_ctrl),     32'(m[2].c));
    if (m[0].v) chk("ex_rd",  32'(ex_rd),  32'(m[0].rd));
    if (m[1].v) chk("mem_rd", 32'(mem_rd), 32'(m[1].rd));
    if (m[2].v) chk("wb_rd",  32'(wb_rd),  32'(m[2].rd));
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(exp_fwd(m[0].rs1)));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(exp_fwd(m[0].rs2)));
    chk("wb_we", 32'(wb_we), 32'(m[2].v && m[2].c.load_regfile && m[2].rd != 0));
    last_stall = exp_stall;
    last_flush = exp_flush;
  endtask

  task automatic drive(input logic v, input rv32i_control_word c, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic st, input logic rr);
    @(negedge clk);
    id_valid = v; id_ctrl = c; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    mem_stall = st; ex_redirect = rr;
    #1;
    compare();
    model_step();
  endtask

  task automatic cyc(input logic v, input rv32i_opcode op, input int rd, input int r1,
                     input int r2, input logic st = 1'b0, input logic rr = 1'b0);
    drive(v, mk_ctrl(op), 5'(rd), 5'(r1), 5'(r2), st, rr);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_ctrl = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    mem_stall = 1'b0; ex_redirect = 1'b0;
    model_reset();
    #7;
    chk("rst_ex_valid",  32'(ex_valid),  32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_wb_valid",  32'(wb_valid),  32'd0);
    chk("rst_ex_ctrl",   32'(ex_ctrl),   32'd0);
    chk("rst_id_stall",  32'(id_stall),  32'd0);
    chk("rst_wb_we",     32'(wb_we),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5 then add x6,x5,x1: one bubble, then WB forward on rs1
    cyc(1, op_load, 5, 1, 0);
    cyc(1, op_reg, 6, 5, 1);
    chk("lu_stall", 32'(id_stall), 32'd1);
    cyc(1, op_reg, 6, 5, 1);
    chk("lu_bubble_ex_valid", 32'(ex_valid), 32'd0);
    chk("lu_released", 32'(id_stall), 32'd0);
    cyc(0, op_imm, 0, 0, 0);
    chk("lu_fwd_a_wb", 32'(fwd_a_sel), 32'd2);
    chk("lu_fwd_b_rf", 32'(fwd_b_sel), 32'd0);

    // add x3,x1,x2 then sub x4,x3,x3: no stall, both from MEM
    cyc(1, op_reg, 3, 1, 2);
    cyc(1, op_reg, 4, 3, 3);
    chk("alu_no_stall", 32'(id_stall), 32'd0);
    cyc(0, op_imm, 0, 0, 0);
    chk("alu_fwd_a_mem", 32'(fwd_a_sel), 32'd1);
    chk("alu_fwd_b_mem", 32'(fwd_b_sel), 32'd1);

    // beq resolves taken in EX while addi sits in ID
    cyc(1, op_br, 0, 1, 2);
    cyc(1, op_imm, 8, 1, 0, 1'b0, 1'b1);
    chk("redir_flush", 32'(flush_if_id), 32'd1);
    chk("redir_no_stall", 32'(id_stall), 32'd0);
    cyc(0, op_imm, 0, 0, 0);
    chk("redir_ex_empty", 32'(ex_valid), 32'd0);
    chk("redir_mem_is_br", 32'(mem_ctrl.opcode), 32'(op_br));

    // full pipe frozen for three cycles
    cyc(1, op_imm, 9, 0, 0);
    cyc(1, op_imm, 10, 0, 0);
    cyc(1, op_imm, 11, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, op_imm, 12, 1, 0, 1'b1, 1'b0);
      chk("frz_id_stall", 32'(id_stall), 32'd1);
      chk("frz_ex_rd",  32'(ex_rd),  32'd11);
      chk("frz_mem_rd", 32'(mem_rd), 32'd10);
      chk("frz_wb_rd",  32'(wb_rd),  32'd9);
      chk("frz_wb_we",  32'(wb_we),  32'd1);
    end

    // lw x0 then use of x0; lw x7 then lui x7 (rs1 field also 7)
    cyc(1, op_load, 0, 1, 0);
    cyc(1, op_reg, 6, 0, 0);
    chk("x0_no_stall", 32'(id_stall), 32'd0);
    cyc(1, op_load, 7, 1, 0);
    cyc(1, op_lui, 7, 7, 7);
    chk("lui_no_stall", 32'(id_stall), 32'd0);

    // asynchronous reset in the middle of a load-use stall
    cyc(1, op_load, 5, 1, 0);
    cyc(1, op_reg, 6, 5, 5);
    chk("pre_rst_stall", 32'(id_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_id_stall",  32'(id_stall),  32'd0);
    chk("arst_ex_valid",  32'(ex_valid),  32'd0);
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_wb_valid",  32'(wb_valid),  32'd0);
    chk("arst_ex_ctrl",   32'(ex_ctrl),   32'd0);
    chk("arst_wb_we",     32'(wb_we),     32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    model_step();

    // randomized traffic on a small register set to provoke hazards
    last_mstall = 1'b0;
    last_redir  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic st, rr;
      st = ($urandom_range(0, 9) < 2);
      rr = last_mstall ? last_redir : ($urandom_range(0, 7) == 0);
      if (last_stall)
        drive(id_valid, id_ctrl, id_rd, id_rs1, id_rs2, st, rr);
      else
        drive(last_flush ? 1'b0 : ($urandom_range(0, 4) != 0),
              mk_ctrl(ops[$urandom_range(0, 9)]),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              st, rr);
      last_mstall = st;
      last_redir  = rr;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
